pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 32, multiply/divide unit latency in cycles, legal range 1..63.
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 SHALL have port clk  in  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs, id_rt  in  5 each  source register numbers of the instruction in the issue stage.
REQ-006 SHALL have ports id_uses_rs, id_uses_rt  in  1 each  issue-stage instruction reads rs or rt.
REQ-007 SHALL have ports ex_rd  in  5, ex_mem_read  in  1  destination register of the EX-stage instruction and its "is load" flag.
REQ-008 SHALL have port ex_branch_taken  in  1  branch or jump resolved taken in EX.
REQ-009 SHALL have ports id_mdu_start, id_mdu_read  in  1 each  issue-stage instruction is mult/div, or is mfhi/mflo.
REQ-010 SHALL have port perf_clr  in  1  synchronous clear of the stall counter.
REQ-011 SHALL have ports pc_en_n, iss_en_n  out  1 each  active-low load enables for the PC and the fetch-issue pipeline register (0 = load).
REQ-012 SHALL have ports iss_flush, ex_bubble  out  1 each  force NOP into the fetch-issue register, or into the issue-execute register.
REQ-013 SHALL have ports mdu_go  out  1, mdu_busy  out  1  MDU start strobe and MDU in progress.
REQ-014 SHALL have port stall_cnt  out  CNT_W  count of stalled cycles.

Function
REQ-015 SHALL detect a load-use hazard (lu) when ex_mem_read=1, ex_rd!=0, and either id_uses_rs=1 with id_rs==ex_rd or id_uses_rt=1 with id_rt==ex_rd.
REQ-016 SHALL detect an MDU hazard (mh) when mdu_busy=1 and either id_mdu_start=1 or id_mdu_read=1.
REQ-017 SHALL define stall = (lu or mh) and not ex_branch_taken.
REQ-018 SHALL produce pc_en_n, iss_en_n, iss_flush, ex_bubble and mdu_go combinationally from current inputs and state, with zero latency.
REQ-019 When stall=1, SHALL drive pc_en_n=1, iss_en_n=1 and ex_bubble=1 (hold PC and issue register, bubble into EX).
REQ-020 When ex_branch_taken=1, SHALL drive pc_en_n=0, iss_en_n=0, iss_flush=1 and ex_bubble=1; the branch overrides any stall in the same cycle.
REQ-021 Otherwise SHALL drive pc_en_n=0, iss_en_n=0, iss_flush=0 and ex_bubble=0.
REQ-022 SHALL drive mdu_go=1 only when id_mdu_start=1, stall=0 and ex_branch_taken=0; an instruction that is squashed or stalled never starts the MDU.
REQ-023 SHALL implement the MDU FSM with states IDLE and BUSY; mdu_busy=1 exactly when the state is BUSY.
REQ-024 In IDLE, mdu_go=1 SHALL load a 6-bit counter with MDU_LAT and move the FSM to BUSY.
REQ-025 In BUSY, the counter SHALL decrement each cycle; when the counter equals 1, the FSM SHALL return to IDLE with the counter at 0.
REQ-026 Consequently, for a start in cycle T, mdu_busy SHALL be 1 in cycles T+1 through T+MDU_LAT, and a dependent mfhi/mflo SHALL issue in cycle T+MDU_LAT+1.
REQ-027 In BUSY, mdu_go SHALL be impossible, because any mdu op raises mh.
REQ-028 SHALL increment stall_cnt by 1 in each cycle with stall=1, saturating at all-ones with no wrap.
REQ-029 perf_clr=1 SHALL zero stall_cnt and SHALL take priority over an increment in the same cycle.
REQ-030 ex_branch_taken SHALL NOT abort an MDU operation already in BUSY.

Reset
REQ-031 While reset=0, SHALL hold the FSM in IDLE, the MDU counter at 0, stall_cnt at 0 and mdu_busy at 0.
REQ-032 With reset=0 and all inputs 0, SHALL output pc_en_n=0, iss_en_n=0, iss_flush=0, ex_bubble=0 and mdu_go=0.
REQ-033 Reset asserted mid-operation SHALL clear BUSY immediately, with no completion strobe.
REQ-034 Reset SHALL be released synchronously to clk by the system.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 for 1 cycle -> pc_en_n=1, iss_en_n=1, ex_bubble=1 that cycle; stall_cnt=1; repeating the test with ex_rd=0 -> no stall.
REQ-036 Branch overrides stall: lu condition together with ex_branch_taken=1 -> pc_en_n=0, iss_en_n=0, iss_flush=1, ex_bubble=1; stall_cnt unchanged.
REQ-037 MDU_LAT=4: id_mdu_start at cycle 0, then id_mdu_read from cycle 1 -> mdu_go pulses at cycle 0, mdu_busy=1 in cycles 1-4, stall in cycles 1-4, mfhi issues at cycle 5, stall_cnt=4.
REQ-038 Back-to-back mult: second id_mdu_start at cycle 2 of BUSY -> stalled until IDLE, then mdu_go exactly once.
REQ-039 Saturation and clear: CNT_W=4 with 20 stall cycles -> stall_cnt=15; asserting perf_clr in the same cycle as a stall -> stall_cnt=0.
REQ-040 Reset mid-BUSY: reset=0 at counter=2 -> mdu_busy=0 immediately, stall_cnt=0, and after release the outputs match REQ-032.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use / MDU hazard stall, branch flush and stall counter
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             id_mdu_start,
    input  logic             id_mdu_read,
    input  logic             perf_clr,
    output logic             pc_en_n,
    output logic             iss_en_n,
    output logic             iss_flush,
    output logic             ex_bubble,
    output logic             mdu_go,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [5:0]       LAT     = 6'(MDU_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0] state;
    logic [5:0] mdu_cnt;
    logic       lu;
    logic       mh;
    logic       stall;

    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    assign mh = mdu_busy && (id_mdu_start || id_mdu_read);

    // A taken branch squashes the issue-stage instruction, so its hazard is moot.
    assign stall = (lu || mh) && !ex_branch_taken;

    assign pc_en_n   = stall;
    assign iss_en_n  = stall;
    assign iss_flush = ex_branch_taken;
    assign ex_bubble = stall || ex_branch_taken;
    assign mdu_go    = id_mdu_start && !stall && !ex_branch_taken;
    assign mdu_busy  = (state == ST_BUSY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            mdu_cnt <= 6'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mdu_go) begin
                        state   <= ST_BUSY;
                        mdu_cnt <= LAT;
                    end
                end
                ST_BUSY: begin
                    if (mdu_cnt == 6'd1) begin
                        state   <= ST_IDLE;
                        mdu_cnt <= 6'd0;
                    end else begin
                        mdu_cnt <= mdu_cnt - 6'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mdu_cnt <= 6'd0;
                end
            endcase
        end
    end

    // Clear wins over a concurrent stall; the counter saturates rather than wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int LAT   = 4;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    typedef struct packed {
        logic          pc_en_n;
        logic          iss_en_n;
        logic          iss_flush;
        logic          ex_bubble;
        logic          mdu_go;
        logic          mdu_busy;
        logic [CW-1:0] stall_cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [4:0]    id_rs = '0;
    logic [4:0]    id_rt = '0;
    logic          id_uses_rs = 1'b0;
    logic          id_uses_rt = 1'b0;
    logic [4:0]    ex_rd = '0;
    logic          ex_mem_read = 1'b0;
    logic          ex_branch_taken = 1'b0;
    logic          id_mdu_start = 1'b0;
    logic          id_mdu_read = 1'b0;
    logic          perf_clr = 1'b0;
    logic          pc_en_n;
    logic          iss_en_n;
    logic          iss_flush;
    logic          ex_bubble;
    logic          mdu_go;
    logic          mdu_busy;
    logic [CW-1:0] stall_cnt;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    int   cyc = 0;
    int   busy_end = -1;
    int   scnt = 0;

    pipe_hazard_ctrl #(.MDU_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .id_mdu_start(id_mdu_start), .id_mdu_read(id_mdu_read), .perf_clr(perf_clr),
        .pc_en_n(pc_en_n), .iss_en_n(iss_en_n), .iss_flush(iss_flush), .ex_bubble(ex_bubble),
        .mdu_go(mdu_go), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus: drive after the falling edge, predict, enqueue.
    task automatic step(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic mr, input logic bt, input logic ms, input logic mrd,
                        input logic pc);
        exp_t e;
        logic busy, lu, mh, stall, go;
        @(negedge clk);
        reset = rst; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        ex_rd = rd; ex_mem_read = mr; ex_branch_taken = bt;
        id_mdu_start = ms; id_mdu_read = mrd; perf_clr = pc;
        if (!rst) begin
            busy_end = -1;
            scnt = 0;
        end
        busy  = rst && (cyc <= busy_end);
        lu    = mr && (rd != 0) && ((urs && rs == rd) || (urt && rt == rd));
        mh    = busy && (ms || mrd);
        stall = (lu || mh) && !bt;
        go    = ms && !stall && !bt;
        e.pc_en_n   = stall;
        e.iss_en_n  = stall;
        e.iss_flush = bt;
        e.ex_bubble = stall || bt;
        e.mdu_go    = go;
        e.mdu_busy  = busy;
        e.stall_cnt = CW'(scnt);
        exp_q.push_back(e);
        if (rst) begin
            if (go) busy_end = cyc + LAT;
            if (pc) scnt = 0;
            else if (stall) scnt = (scnt < SAT) ? scnt + 1 : SAT;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pc_en_n, iss_en_n, iss_flush, ex_bubble, mdu_go, mdu_busy, stall_cnt};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t actual pc_en_n/iss_en_n/flush/bubble/go/busy/cnt=%b%b%b%b%b%b/%0d required %b%b%b%b%b%b/%0d",
                             $time, a.pc_en_n, a.iss_en_n, a.iss_flush, a.ex_bubble, a.mdu_go,
                             a.mdu_busy, a.stall_cnt, e.pc_en_n, e.iss_en_n, e.iss_flush,
                             e.ex_bubble, e.mdu_go, e.mdu_busy, e.stall_cnt);
                end
            end
        end
    end

    initial begin : stimulus
        logic [4:0] r1, r2, r3;
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use, then ex_rd=0, then branch overriding the hazard
        step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
        step(1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0);
        step(1, 0, 7, 0, 1, 7, 1, 0, 0, 0, 0);
        idle(1);
        // mult then dependent mfhi stalls through the whole latency
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < LAT + 1; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        // back-to-back mult
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        for (int i = 0; i < LAT + 1; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // branch during BUSY does not abort the MDU
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(LAT + 1);
        // saturation, then clear concurrent with a stall
        for (int i = 0; i < 20; i++) step(1, 3, 0, 1, 0, 3, 1, 0, 0, 0, 0);
        step(1, 3, 0, 1, 0, 3, 1, 0, 0, 0, 1);
        idle(1);
        // reset mid-BUSY
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 2, 0, 1, 0, 2, 1, 0, 0, 0, 0);
        step(1, 2, 0, 1, 0, 2, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3000; i++) begin
            r1 = 5'($urandom_range(0, 3));
            r2 = 5'($urandom_range(0, 3));
            r3 = 5'($urandom_range(0, 3));
            step(($urandom_range(0, 99) != 0), r1, r2,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r3,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 30) == 0));
        end
        idle(1);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual pending=%0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
